// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM encoding and the
// address-alignment helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  // Ceiling log2; clogb2(1) = 0.
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one held response out,
// with a saturating counter of non-OKAY responses.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_WIDTH    = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [2:0]  PROT_VALUE    = 3'b000,
  parameter int          ERR_CNT_WIDTH = 16
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_ARESET,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0]     AXI_AWADDR,
  output logic [2:0]                AXI_AWPROT,
  output logic                      AXI_AWVALID,
  input  logic                      AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   AXI_WSTRB,
  output logic                      AXI_WVALID,
  input  logic                      AXI_WREADY,
  input  logic [1:0]                AXI_BRESP,
  input  logic                      AXI_BVALID,
  output logic                      AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     AXI_ARADDR,
  output logic [2:0]                AXI_ARPROT,
  output logic                      AXI_ARVALID,
  input  logic                      AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     AXI_RDATA,
  input  logic [1:0]                AXI_RRESP,
  input  logic                      AXI_RVALID,
  output logic                      AXI_RREADY
);

  localparam int ADDR_LSB = clogb2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << ADDR_LSB) - ADDR_WIDTH'(1));

  state_t state_reg;

  assign AXI_AWPROT = PROT_VALUE;
  assign AXI_ARPROT = PROT_VALUE;

  function automatic logic [ERR_CNT_WIDTH-1:0] err_next(
    input logic [ERR_CNT_WIDTH-1:0] count,
    input logic [1:0]               resp
  );
    if (resp != RESP_OKAY && count != {ERR_CNT_WIDTH{1'b1}})
      return count + ERR_CNT_WIDTH'(1);
    return count;
  endfunction

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_reg   <= S_IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      err_count   <= '0;
      AXI_AWADDR  <= '0;
      AXI_AWVALID <= 1'b0;
      AXI_WDATA   <= '0;
      AXI_WSTRB   <= '0;
      AXI_WVALID  <= 1'b0;
      AXI_BREADY  <= 1'b0;
      AXI_ARADDR  <= '0;
      AXI_ARVALID <= 1'b0;
      AXI_RREADY  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              AXI_AWADDR  <= cmd_addr & ADDR_MASK;
              AXI_WDATA   <= cmd_wdata;
              AXI_WSTRB   <= cmd_wstrb;
              AXI_AWVALID <= 1'b1;
              AXI_WVALID  <= 1'b1;
              state_reg   <= S_WR;
            end else begin
              AXI_ARADDR  <= cmd_addr & ADDR_MASK;
              AXI_ARVALID <= 1'b1;
              state_reg   <= S_RD_ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_WR: begin
          // AW and W complete independently; leave once neither is still pending.
          if (AXI_AWVALID && AXI_AWREADY) AXI_AWVALID <= 1'b0;
          if (AXI_WVALID && AXI_WREADY) AXI_WVALID <= 1'b0;
          if ((!AXI_AWVALID || AXI_AWREADY) && (!AXI_WVALID || AXI_WREADY)) begin
            AXI_BREADY <= 1'b1;
            state_reg  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (AXI_BVALID) begin
            AXI_BREADY <= 1'b0;
            rsp_write  <= 1'b1;
            rsp_rdata  <= '0;
            rsp_resp   <= AXI_BRESP;
            err_count  <= err_next(err_count, AXI_BRESP);
            rsp_valid  <= 1'b1;
            state_reg  <= S_RESP;
          end
        end
        S_RD_ADDR: begin
          if (AXI_ARREADY) begin
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b1;
            state_reg   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (AXI_RVALID) begin
            AXI_RREADY <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= AXI_RDATA;
            rsp_resp   <= AXI_RRESP;
            err_count  <= err_next(err_count, AXI_RRESP);
            rsp_valid  <= 1'b1;
            state_reg  <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a small register-file slave with a one-cycle
// response pipeline, table-driven transactions and hand-written corner sequences.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr  = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_ready = 1'b0;

  wire         cmd_ready, rsp_valid, rsp_write;
  wire  [31:0] rsp_rdata;
  wire  [1:0]  rsp_resp;
  wire  [15:0] err_count;
  wire  [31:0] awaddr, wdata, araddr;
  wire  [2:0]  awprot, arprot;
  wire  [3:0]  wstrb;
  wire         awvalid, wvalid, bready, arvalid, rready;
  wire         awready, wready, arready;

  wire         s_cmd_ready, s_rsp_valid, s_rsp_write;
  wire  [31:0] s_rsp_rdata, s_awaddr, s_wdata, s_araddr;
  wire  [1:0]  s_rsp_resp;
  wire  [1:0]  s_err_count;
  wire  [2:0]  s_awprot, s_arprot;
  wire  [3:0]  s_wstrb;
  wire         s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;

  // slave model state
  logic [31:0] mem [16];
  logic [1:0]  bresp, rresp;
  logic        bvalid, rvalid;
  logic [31:0] rdata;
  logic [31:0] aw_q, wd_q, ar_q;
  logic [3:0]  ws_q;
  logic        aw_done, w_done, wr_commit, rd_pend;
  int          cyc;
  int          aw_at = 0, w_at = 0, ar_at = 0;
  logic [1:0]  slave_resp = 2'b00;

  int checks = 0;
  int errors = 0;

  logic        hist_awv [64];
  logic        hist_wv  [64];
  logic        hist_br  [64];
  logic [31:0] hist_awaddr [64];
  logic [31:0] hist_wdata  [64];
  logic [31:0] hist_axaddr [64];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  sresp;
    logic [31:0] exp_axaddr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT_VALUE(3'b000), .ERR_CNT_WIDTH(16)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
    .AXI_AWADDR(awaddr), .AXI_AWPROT(awprot), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARPROT(arprot), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
  );

  // Narrow-counter twin fed identical inputs, so saturation is reached in a few errors.
  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT_VALUE(3'b000), .ERR_CNT_WIDTH(2)) dut_sat (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(s_rsp_write),
    .rsp_rdata(s_rsp_rdata), .rsp_resp(s_rsp_resp), .err_count(s_err_count),
    .AXI_AWADDR(s_awaddr), .AXI_AWPROT(s_awprot), .AXI_AWVALID(s_awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(s_wdata), .AXI_WSTRB(s_wstrb), .AXI_WVALID(s_wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(s_bready),
    .AXI_ARADDR(s_araddr), .AXI_ARPROT(s_arprot), .AXI_ARVALID(s_arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(s_rready)
  );

  assign awready = (aw_at == 0) || (cyc == aw_at);
  assign wready  = (w_at == 0)  || (cyc == w_at);
  assign arready = (ar_at == 0) || (cyc == ar_at);

  // cyc counts cycles since command acceptance (1 = first cycle after it).
  always @(posedge clk) begin
    if (rst) begin
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= '0; rresp <= '0; rdata <= '0;
      aw_done <= 1'b0; w_done <= 1'b0; wr_commit <= 1'b0; rd_pend <= 1'b0;
      aw_q <= '0; wd_q <= '0; ws_q <= '0; ar_q <= '0; cyc <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      cyc <= (cmd_valid && cmd_ready) ? 1 : cyc + 1;
      if (awvalid && awready) begin aw_q <= awaddr; aw_done <= 1'b1; end
      if (wvalid && wready) begin wd_q <= wdata; ws_q <= wstrb; w_done <= 1'b1; end
      if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
        wr_commit <= 1'b1; aw_done <= 1'b0; w_done <= 1'b0;
      end
      if (wr_commit) begin
        for (int b = 0; b < 4; b++)
          if (ws_q[b]) mem[aw_q[5:2]][b*8 +: 8] <= wd_q[b*8 +: 8];
        bvalid <= 1'b1; bresp <= slave_resp; wr_commit <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin ar_q <= araddr; rd_pend <= 1'b1; end
      if (rd_pend) begin
        rdata <= mem[ar_q[5:2]]; rresp <= slave_resp; rvalid <= 1'b1; rd_pend <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one command from a negedge, record per-cycle channel activity, and
  // optionally consume the response. Returns the cycle rsp_valid was first seen.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input bit consume, output int lat);
    int n;
    lat = 0;
    for (int k = 0; k < 64; k++) begin
      hist_awv[k] = 1'b0; hist_wv[k] = 1'b0; hist_br[k] = 1'b0;
      hist_awaddr[k] = '0; hist_wdata[k] = '0; hist_axaddr[k] = '0;
    end
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready_before_issue", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    @(posedge clk);
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      hist_awv[k] = awvalid; hist_wv[k] = wvalid; hist_br[k] = bready;
      hist_awaddr[k] = awaddr; hist_wdata[k] = wdata;
      hist_axaddr[k] = wr ? awaddr : araddr;
      if (rsp_valid === 1'b1) begin lat = k; break; end
    end
    chk("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    if (consume) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int bad;
    int n;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h4,  32'h0000_0000, 2'b00, 16'd0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b00, 32'h4,  32'hDEAD_BEEF, 2'b00, 16'd0};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3, 2'b00, 32'h8,  32'h0000_0000, 2'b00, 16'd0};
    vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'h8,  32'h0000_5678, 2'b00, 16'd0};
    vecs[4]  = '{1'b1, 32'h0000_000B, 32'hAABB_CCDD, 4'hC, 2'b00, 32'h8,  32'h0000_0000, 2'b00, 16'd0};
    vecs[5]  = '{1'b0, 32'h0000_000A, 32'h0,         4'h0, 2'b00, 32'h8,  32'hAABB_5678, 2'b00, 16'd0};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 2'b10, 32'h4,  32'hDEAD_BEEF, 2'b10, 16'd1};
    vecs[7]  = '{1'b0, 32'h0000_0005, 32'h0,         4'h0, 2'b10, 32'h4,  32'hDEAD_BEEF, 2'b10, 16'd2};
    vecs[8]  = '{1'b0, 32'h0000_0007, 32'h0,         4'h0, 2'b10, 32'h4,  32'hDEAD_BEEF, 2'b10, 16'd3};
    vecs[9]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b11, 32'hC,  32'h0000_0000, 2'b11, 16'd4};
    vecs[10] = '{1'b1, 32'h0000_0010, 32'h0000_0055, 4'hF, 2'b01, 32'h10, 32'h0000_0000, 2'b01, 16'd5};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero",
        {cmd_ready, rsp_valid, rsp_write, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    chk("reset_data_zero", {rsp_rdata, awaddr} | {wdata, araddr}, 64'd0);
    chk("reset_err_count", err_count, 64'd0);
    chk("reset_rsp_resp_wstrb", {rsp_resp, wstrb}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 64'd1);
    chk("prot_value", {awprot, arprot}, 64'd0);

    // Table-driven transactions with zero-wait readies
    for (int i = 0; i < 11; i++) begin
      slave_resp = vecs[i].sresp;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, lat);
      $display("txn %0d wr=%0b addr=%h rdata=%h resp=%0d err=%0d lat=%0d",
               i, vecs[i].wr, vecs[i].addr, rsp_rdata, rsp_resp, err_count, lat);
      chk($sformatf("v%0d_latency", i), lat, 64'd4);
      chk($sformatf("v%0d_axaddr", i), hist_axaddr[1], vecs[i].exp_axaddr);
      chk($sformatf("v%0d_rsp_write", i), rsp_write, vecs[i].wr);
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_rsp_resp", i), rsp_resp, vecs[i].exp_resp);
      chk($sformatf("v%0d_err_count", i), err_count, vecs[i].exp_err);
      chk($sformatf("v%0d_sat_err_count", i), s_err_count,
          (vecs[i].exp_err > 16'd3) ? 64'd3 : 64'(vecs[i].exp_err));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_dropped", i), {cmd_ready, rsp_valid}, 64'b10);
      if (i == 0) chk("slave_reg1", mem[1], 64'hDEAD_BEEF);
    end
    slave_resp = 2'b00;

    // AWREADY in cycle 2, WREADY in cycle 5
    aw_at = 2; w_at = 5;
    run_txn(1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF, 1'b1, lat);
    $display("txn stub_write lat=%0d", lat);
    chk("stub_awvalid_c2", hist_awv[2], 64'd1);
    chk("stub_awvalid_c3", hist_awv[3], 64'd0);
    chk("stub_wvalid_c5", hist_wv[5], 64'd1);
    chk("stub_wvalid_c6", hist_wv[6], 64'd0);
    chk("stub_bready_c5", hist_br[5], 64'd0);
    chk("stub_bready_c6", hist_br[6], 64'd1);
    chk("stub_awaddr_c2", hist_awaddr[2], 64'h14);
    chk("stub_wdata_c1", hist_wdata[1], 64'hCAFE_F00D);
    chk("stub_wdata_c5", hist_wdata[5], 64'hCAFE_F00D);
    chk("stub_latency", lat, 64'd8);
    aw_at = 0; w_at = 0;

    // Response back-pressure with a pending command
    run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b0, lat);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0014;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'b00 ||
          rsp_write !== 1'b0 || cmd_ready !== 1'b0 || arvalid !== 1'b0 ||
          awvalid !== 1'b0 || wvalid !== 1'b0) bad++;
    end
    $display("txn backpressure bad_cycles=%0d", bad);
    chk("bp_stable_cycles_bad", bad, 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_release_cmd_ready", {cmd_ready, rsp_valid}, 64'b10);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_arvalid", {cmd_ready, arvalid}, 64'b01);
    chk("bp_next_araddr", araddr, 64'h14);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("bp_next_rdata", rsp_rdata, 64'hCAFE_F00D);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset while ARVALID waits for ARREADY
    ar_at = 100;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_arvalid_pending", arvalid, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    $display("txn reset_abort arvalid=%0b err=%0d", arvalid, err_count);
    chk("abort_channels_zero", {arvalid, rready, rsp_valid, cmd_ready}, 64'd0);
    chk("abort_err_count", err_count, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 64'd1);
    ar_at = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
